// File: rtl/ftdi_order_decoder_if.sv
// FIFO-side and register-side signals of the FTDI order decoder.
// The decoder uses the master modport; the FIFO/register model uses the slave modport.
interface ftdi_order_decoder_if #(
    parameter int ADDR_BYTES = 1
) ();
    localparam int ADDR_W = 8 * ADDR_BYTES;

    logic [7:0]        ri_data;
    logic              ri_empty;
    logic              ri_read;
    logic              pcreadfifofull;
    logic [ADDR_W-1:0] address;
    logic [7:0]        value;
    logic              write;
    logic              read;

    modport master (
        input  ri_data, ri_empty, pcreadfifofull,
        output ri_read, address, value, write, read
    );

    modport slave (
        output ri_data, ri_empty, pcreadfifofull,
        input  ri_read, address, value, write, read
    );
endinterface

// File: rtl/ftdi_order_decoder.sv
// Decodes header/address/length/payload orders from an FWFT byte FIFO into
// single-cycle register write/read strobes, with timeout abort and error counting.
module ftdi_order_decoder #(
    parameter int ADDR_BYTES = 1,
    parameter int LEN_BYTES  = 2,
    parameter int TIMEOUT    = 1000000
) (
    input  logic                 clk,
    input  logic                 res_n,
    ftdi_order_decoder_if.master bus,
    output logic                 busy,
    output logic [2:0]           state,
    output logic                 timeout_err,
    output logic                 opcode_err,
    output logic [7:0]           err_count
);
    localparam int ADDR_W = 8 * ADDR_BYTES;
    localparam int LEN_W  = 8 * LEN_BYTES;
    localparam int TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0]    LEN_LAST  = 2'(LEN_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LEN   = 3'd2,
        S_WDATA = 3'd3,
        S_RDATA = 3'd4
    } state_t;

    state_t            cur, nxt;
    logic [ADDR_W-1:0] addr_q, addr_shift;
    logic [LEN_W-1:0]  remain, len_shift;
    logic [1:0]        op;        // bit0: read order, bit1: auto-increment
    logic [1:0]        byte_cnt;
    logic [TW-1:0]     tmo_cnt;
    logic              pop, timed, tmo_hit, op_bad, do_write, do_read;

    assign pop         = (cur != S_RDATA) && !bus.ri_empty;
    assign bus.ri_read = pop;
    assign timed       = (cur == S_ADDR) || (cur == S_LEN) || (cur == S_WDATA);
    assign tmo_hit     = timed && bus.ri_empty && (tmo_cnt == TMO_LAST);
    assign addr_shift  = ADDR_W'({addr_q, bus.ri_data});
    assign len_shift   = LEN_W'({remain, bus.ri_data});
    assign busy        = (cur != S_IDLE);
    assign state       = cur;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        op_bad   = 1'b0;
        do_write = 1'b0;
        do_read  = 1'b0;
        case (cur)
            S_IDLE: begin
                if (pop) begin
                    if (bus.ri_data[7:6] != 2'b00) op_bad = 1'b1;
                    else                           nxt    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (tmo_hit)                             nxt = S_IDLE;
                else if (pop && byte_cnt == ADDR_LAST)   nxt = S_LEN;
            end
            S_LEN: begin
                if (tmo_hit) nxt = S_IDLE;
                else if (pop && byte_cnt == LEN_LAST) begin
                    if (len_shift == '0) nxt = S_IDLE;
                    else if (op[0])      nxt = S_RDATA;
                    else                 nxt = S_WDATA;
                end
            end
            S_WDATA: begin
                if (tmo_hit) nxt = S_IDLE;
                else if (pop) begin
                    do_write = 1'b1;
                    if (remain == LEN_W'(1)) nxt = S_IDLE;
                end
            end
            S_RDATA: begin
                // back-pressure holds the order without counting toward timeout
                if (!bus.pcreadfifofull) begin
                    do_read = 1'b1;
                    if (remain == LEN_W'(1)) nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            bus.write   <= 1'b0;
            bus.read    <= 1'b0;
            bus.value   <= '0;
            bus.address <= '0;
            timeout_err <= 1'b0;
            opcode_err  <= 1'b0;
            err_count   <= '0;
            tmo_cnt     <= '0;
            addr_q      <= '0;
            remain      <= '0;
            op          <= '0;
            byte_cnt    <= '0;
        end else begin
            bus.write   <= do_write;
            bus.read    <= do_read;
            timeout_err <= tmo_hit;
            opcode_err  <= op_bad;
            if ((tmo_hit || op_bad) && err_count != 8'hFF) err_count <= err_count + 8'd1;
            tmo_cnt <= (timed && bus.ri_empty && !tmo_hit) ? tmo_cnt + 1'b1 : '0;
            if (do_write) bus.value <= bus.ri_data;
            // strobe address is latched separately so the increment never shows during a strobe
            if (do_write || do_read) begin
                bus.address <= addr_q;
                remain      <= remain - 1'b1;
                if (op[1]) addr_q <= addr_q + 1'b1;
            end
            case (cur)
                S_IDLE: begin
                    byte_cnt <= '0;
                    if (pop) op <= bus.ri_data[5:4];
                end
                S_ADDR: if (pop) begin
                    addr_q   <= addr_shift;
                    byte_cnt <= (byte_cnt == ADDR_LAST) ? 2'd0 : byte_cnt + 2'd1;
                end
                S_LEN: if (pop) begin
                    remain   <= len_shift;
                    byte_cnt <= (byte_cnt == LEN_LAST) ? 2'd0 : byte_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ftdi_order_decoder.sv
// Directed bench for ftdi_order_decoder: FWFT FIFO model feeding hand-built orders,
// outputs sampled on the falling edge and compared against hand-computed values.
module tb_ftdi_order_decoder;
    logic       clk = 1'b0;
    logic       res_n;
    logic       busy, timeout_err, opcode_err;
    logic [2:0] state;
    logic [7:0] err_count;
    int         errors = 0;
    int         checks = 0;

    logic [7:0] mem [0:2047];
    int         wptr = 0;
    int         rptr;

    ftdi_order_decoder_if #(.ADDR_BYTES(1)) bus ();

    ftdi_order_decoder #(.ADDR_BYTES(1), .LEN_BYTES(2), .TIMEOUT(16)) dut (
        .clk         (clk),
        .res_n       (res_n),
        .bus         (bus.master),
        .busy        (busy),
        .state       (state),
        .timeout_err (timeout_err),
        .opcode_err  (opcode_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model; reset flushes whatever is still queued
    assign bus.ri_empty = (rptr >= wptr);
    assign bus.ri_data  = mem[rptr];
    always @(posedge clk or negedge res_n) begin
        if (!res_n)           rptr <= wptr;
        else if (bus.ri_read) rptr <= rptr + 1;
    end

    task automatic push(input logic [7:0] b);
        mem[wptr] = b;
        wptr = wptr + 1;
    endtask

    task automatic test_reset;
        res_n = 1'b0;
        bus.pcreadfifofull = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.write, bus.read, busy, timeout_err, opcode_err, bus.ri_read} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=000000",
                     {bus.write, bus.read, busy, timeout_err, opcode_err, bus.ri_read});
        end
        checks++;
        if ({bus.address, bus.value, state, err_count} !== 27'd0) begin
            errors++;
            $display("FAIL reset_values addr=%h value=%h state=%0d err_count=%0d want all 0",
                     bus.address, bus.value, state, err_count);
        end
        res_n = 1'b1;
    endtask

    task automatic test_wr;
        logic [7:0] exp_v [3];
        int n = 0, first = -1, last = -10;
        exp_v[0] = 8'hAA; exp_v[1] = 8'hBB; exp_v[2] = 8'hCC;
        @(negedge clk);
        push(8'h00); push(8'h12); push(8'h00); push(8'h03);
        push(8'hAA); push(8'hBB); push(8'hCC);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.write) begin
                if (n < 3) begin
                    checks++;
                    if (bus.address !== 8'h12 || bus.value !== exp_v[n]) begin
                        errors++;
                        $display("FAIL wr_data[%0d] got=%h@%h want=%h@12", n, bus.value, bus.address, exp_v[n]);
                    end
                end
                if (n > 0) begin
                    checks++;
                    if (c !== last + 1) begin
                        errors++;
                        $display("FAIL wr_consecutive got cycle=%0d want=%0d", c, last + 1);
                    end
                end else first = c;
                last = c;
                n++;
            end
        end
        checks++;
        if (n !== 3 || first !== 4) begin
            errors++;
            $display("FAIL wr_count got n=%0d first=%0d want n=3 first=4", n, first);
        end
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL wr_end_state got=%0d want=0", state);
        end
    endtask

    task automatic test_wr_inc;
        logic [7:0] exp_a [2];
        logic [7:0] exp_v [2];
        int n = 0;
        exp_a[0] = 8'hFF; exp_a[1] = 8'h00;
        exp_v[0] = 8'h11; exp_v[1] = 8'h22;
        @(negedge clk);
        push(8'h20); push(8'hFF); push(8'h00); push(8'h02); push(8'h11); push(8'h22);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.write && n < 2) begin
                checks++;
                if (bus.address !== exp_a[n] || bus.value !== exp_v[n]) begin
                    errors++;
                    $display("FAIL wrinc_data[%0d] got=%h@%h want=%h@%h", n, bus.value, bus.address, exp_v[n], exp_a[n]);
                end
                if (n == 1) begin
                    checks++;
                    if (busy !== 1'b0) begin
                        errors++;
                        $display("FAIL wrinc_busy got=%b want=0", busy);
                    end
                end
                n++;
            end else if (bus.write) n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL wrinc_count got=%0d want=2", n);
        end
    endtask

    task automatic test_rd_inc;
        int n = 0, last = -10, wait_c = 0, wr_seen = 0;
        @(negedge clk);
        push(8'h30); push(8'h40); push(8'h00); push(8'h04);
        push(8'h00); push(8'h50); push(8'h00); push(8'h00);
        while (state !== 3'd4 && wait_c < 20) begin
            @(negedge clk);
            wait_c++;
        end
        checks++;
        if (state !== 3'd4 || bus.read !== 1'b0) begin
            errors++;
            $display("FAIL rd_enter got state=%0d read=%b want state=4 read=0", state, bus.read);
        end
        bus.pcreadfifofull = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.read !== 1'b0 || bus.ri_read !== 1'b0 || state !== 3'd4) begin
                errors++;
                $display("FAIL rd_full_hold got read=%b ri_read=%b state=%0d want 0 0 4",
                         bus.read, bus.ri_read, state);
            end
        end
        bus.pcreadfifofull = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.write) wr_seen++;
            if (state == 3'd4) begin
                checks++;
                if (bus.ri_read !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_no_pop got ri_read=%b want=0", bus.ri_read);
                end
            end
            if (bus.read) begin
                checks++;
                if (bus.address !== 8'h40 + 8'(n) || (n > 0 && c != last + 1)) begin
                    errors++;
                    $display("FAIL rd_addr[%0d] got=%h cycle=%0d want=%h", n, bus.address, c, 8'h40 + 8'(n));
                end
                last = c;
                n++;
            end
        end
        checks++;
        if (n !== 4 || wr_seen !== 0 || state !== 3'd0 || rptr !== wptr) begin
            errors++;
            $display("FAIL rd_summary got reads=%0d writes=%0d state=%0d left=%0d want 4 0 0 0",
                     n, wr_seen, state, wptr - rptr);
        end
    endtask

    task automatic test_timeout;
        int first = -1, pulses = 0, reads = 0;
        @(negedge clk);
        push(8'h00); push(8'h12);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (timeout_err) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    checks++;
                    if (state !== 3'd0 || err_count !== 8'd1) begin
                        errors++;
                        $display("FAIL tmo_pulse_state got state=%0d err_count=%0d want 0 1", state, err_count);
                    end
                end
            end
        end
        checks++;
        if (first !== 17 || pulses !== 1) begin
            errors++;
            $display("FAIL tmo_timing got cycle=%0d pulses=%0d want cycle=17 pulses=1", first, pulses);
        end
        push(8'h10); push(8'h33); push(8'h00); push(8'h01);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.read) begin
                reads++;
                checks++;
                if (bus.address !== 8'h33) begin
                    errors++;
                    $display("FAIL tmo_next_addr got=%h want=33", bus.address);
                end
            end
        end
        checks++;
        if (reads !== 1 || err_count !== 8'd1) begin
            errors++;
            $display("FAIL tmo_next_order got reads=%0d err_count=%0d want 1 1", reads, err_count);
        end
    endtask

    task automatic test_opcode;
        int pulses = 0, busy_seen = 0;
        @(negedge clk);
        push(8'h70);
        @(negedge clk);
        checks++;
        if (opcode_err !== 1'b1 || state !== 3'd0 || err_count !== 8'd2) begin
            errors++;
            $display("FAIL op_pulse got err=%b state=%0d err_count=%0d want 1 0 2", opcode_err, state, err_count);
        end
        @(negedge clk);
        checks++;
        if (opcode_err !== 1'b0) begin
            errors++;
            $display("FAIL op_pulse_width got=%b want=0", opcode_err);
        end
        for (int i = 0; i < 300; i++) push(8'h70);
        for (int c = 0; c < 320; c++) begin
            @(negedge clk);
            if (opcode_err) pulses++;
            if (busy) busy_seen++;
        end
        checks++;
        if (pulses !== 300 || busy_seen !== 0) begin
            errors++;
            $display("FAIL op_burst got pulses=%0d busy_cycles=%0d want 300 0", pulses, busy_seen);
        end
        checks++;
        if (err_count !== 8'd255) begin
            errors++;
            $display("FAIL op_saturate got=%0d want=255", err_count);
        end
    endtask

    task automatic test_reset_mid;
        int n = 0, wait_c = 0, late = 0;
        @(negedge clk);
        push(8'h00); push(8'h55); push(8'h00); push(8'h04); push(8'h01); push(8'h02);
        while (n < 2 && wait_c < 20) begin
            @(negedge clk);
            if (bus.write) n++;
            wait_c++;
        end
        checks++;
        if (n !== 2 || state !== 3'd3) begin
            errors++;
            $display("FAIL mid_setup got writes=%0d state=%0d want 2 3", n, state);
        end
        res_n = 1'b0;
        #1;
        checks++;
        if ({bus.write, bus.read, busy, timeout_err, opcode_err, bus.ri_read} !== 6'b0 ||
            {bus.address, bus.value, state, err_count} !== 27'd0) begin
            errors++;
            $display("FAIL mid_reset got w=%b r=%b busy=%b addr=%h val=%h state=%0d cnt=%0d want all 0",
                     bus.write, bus.read, busy, bus.address, bus.value, state, err_count);
        end
        @(negedge clk);
        res_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.write || bus.read) late++;
        end
        checks++;
        if (late !== 0 || state !== 3'd0) begin
            errors++;
            $display("FAIL mid_after got strobes=%0d state=%0d want 0 0", late, state);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_wr();
        test_wr_inc();
        test_rd_inc();
        test_timeout();
        test_opcode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
